// File: rtl/wam_game_core.sv
// Whack-a-mole game engine: LFSR-driven mole spawner, tap hit detection,
// saturating 3-digit BCD score, per-second countdown and end-of-round flag.
module wam_game_core #(
    parameter int          TICKS_PER_SEC = 100,
    parameter int          GAME_SECS     = 30,
    parameter int          GAP_TICKS     = 20,
    parameter int          LIFE_UNIT     = 25,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick,
    input  logic        start,
    input  logic [7:0]  tap,
    input  logic [3:0]  hrdn,
    output logic [7:0]  holes,
    output logic [11:0] score,
    output logic [4:0]  time_display,
    output logic        pause
);

    localparam logic [15:0] SEC_LAST  = 16'(TICKS_PER_SEC - 1);
    localparam logic [15:0] GAP_INIT  = 16'(GAP_TICKS);
    localparam logic [4:0]  SECS_INIT = 5'(GAME_SECS);
    localparam logic [15:0] LIFE_L0   = 16'(4 * LIFE_UNIT);
    localparam logic [15:0] LIFE_L1   = 16'(3 * LIFE_UNIT);
    localparam logic [15:0] LIFE_L2   = 16'(2 * LIFE_UNIT);
    localparam logic [15:0] LIFE_L3   = 16'(1 * LIFE_UNIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Galois form of x^16+x^14+x^13+x^11, shifting right.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = {1'b0, v[15:1]};
        if (v[0]) begin
            r = r ^ 16'hB400;
        end else begin
            r = r;
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v == 12'h999) begin
            r = v;
        end else if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else if (v[7:4] != 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = v[7:4] + 4'd1;
        end else begin
            r[7:0]  = 8'h00;
            r[11:8] = v[11:8] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [15:0] life_of(input logic [3:0] d);
        logic [15:0] r;
        case (d)
            4'd0:    r = LIFE_L0;
            4'd1:    r = LIFE_L1;
            4'd2:    r = LIFE_L2;
            default: r = LIFE_L3;
        endcase
        return r;
    endfunction

    state_t      state_r, state_next_s;
    logic [7:0]  holes_r, holes_next_s;
    logic [11:0] score_r, score_next_s;
    logic [4:0]  secs_left_r, secs_next_s;
    logic        pause_r, pause_next_s;
    logic [15:0] lfsr_r;
    logic        start_q_r;
    logic [7:0]  tap_q_r;
    logic [15:0] sec_cnt_r, sec_next_s;
    logic [15:0] gap_cnt_r, gap_next_s;
    logic [15:0] life_cnt_r, life_next_s;
    logic [2:0]  prev_hole_r, prev_next_s;

    logic        start_edge_s;
    logic [7:0]  tap_edge_s;
    logic        hit_s;
    logic        time_up_s;
    logic [2:0]  spawn_hole_s;

    assign start_edge_s = start & ~start_q_r;
    assign tap_edge_s   = tap & ~tap_q_r;
    assign hit_s        = |(tap_edge_s & holes_r);
    assign time_up_s    = tick && (sec_cnt_r == SEC_LAST) && (secs_left_r == 5'd1);
    // Never repeat the previous hole back to back.
    assign spawn_hole_s = (lfsr_r[2:0] == prev_hole_r) ? (lfsr_r[2:0] + 3'd1) : lfsr_r[2:0];

    // Next-state and next-output computation for the game FSM.
    always_comb begin
        state_next_s = state_r;
        holes_next_s = holes_r;
        score_next_s = score_r;
        secs_next_s  = secs_left_r;
        pause_next_s = pause_r;
        sec_next_s   = sec_cnt_r;
        gap_next_s   = gap_cnt_r;
        life_next_s  = life_cnt_r;
        prev_next_s  = prev_hole_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_edge_s) begin
                    state_next_s = ST_PLAY;
                    score_next_s = 12'h000;
                    secs_next_s  = SECS_INIT;
                    holes_next_s = 8'h00;
                    sec_next_s   = 16'd0;
                    gap_next_s   = GAP_INIT;
                    pause_next_s = 1'b0;
                end else begin
                    holes_next_s = 8'h00;
                end
            end
            ST_PLAY: begin
                if (time_up_s) begin
                    // Round end outranks a same-cycle hit.
                    state_next_s = ST_DONE;
                    holes_next_s = 8'h00;
                    pause_next_s = 1'b1;
                    secs_next_s  = 5'd0;
                    sec_next_s   = 16'd0;
                end else begin
                    if (tick) begin
                        if (sec_cnt_r == SEC_LAST) begin
                            sec_next_s  = 16'd0;
                            secs_next_s = secs_left_r - 5'd1;
                        end else begin
                            sec_next_s = sec_cnt_r + 16'd1;
                        end
                    end else begin
                        sec_next_s = sec_cnt_r;
                    end
                    if (hit_s) begin
                        holes_next_s = 8'h00;
                        gap_next_s   = GAP_INIT;
                        score_next_s = bcd_inc(score_r);
                    end else if (tick && (holes_r != 8'h00)) begin
                        if (life_cnt_r <= 16'd1) begin
                            holes_next_s = 8'h00;
                            gap_next_s   = GAP_INIT;
                            life_next_s  = 16'd0;
                        end else begin
                            life_next_s = life_cnt_r - 16'd1;
                        end
                    end else if (tick) begin
                        if (gap_cnt_r <= 16'd1) begin
                            holes_next_s = 8'h01 << spawn_hole_s;
                            life_next_s  = life_of(hrdn);
                            prev_next_s  = spawn_hole_s;
                            gap_next_s   = 16'd0;
                        end else begin
                            gap_next_s = gap_cnt_r - 16'd1;
                        end
                    end else begin
                        holes_next_s = holes_r;
                    end
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                holes_next_s = 8'h00;
                pause_next_s = 1'b0;
            end
        endcase
    end

    // State, counters, LFSR and input-edge registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r     <= ST_IDLE;
            holes_r     <= 8'h00;
            score_r     <= 12'h000;
            secs_left_r <= SECS_INIT;
            pause_r     <= 1'b0;
            lfsr_r      <= LFSR_SEED;
            start_q_r   <= 1'b0;
            tap_q_r     <= 8'h00;
            sec_cnt_r   <= 16'd0;
            gap_cnt_r   <= 16'd0;
            life_cnt_r  <= 16'd0;
            prev_hole_r <= 3'd0;
        end else begin
            state_r     <= state_next_s;
            holes_r     <= holes_next_s;
            score_r     <= score_next_s;
            secs_left_r <= secs_next_s;
            pause_r     <= pause_next_s;
            lfsr_r      <= lfsr_step(lfsr_r);
            start_q_r   <= start;
            tap_q_r     <= tap;
            sec_cnt_r   <= sec_next_s;
            gap_cnt_r   <= gap_next_s;
            life_cnt_r  <= life_next_s;
            prev_hole_r <= prev_next_s;
        end
    end

    assign holes        = holes_r;
    assign score        = score_r;
    assign time_display = secs_left_r;
    assign pause        = pause_r;

endmodule
